composite_encoder: RTL

COMPOSITE_ENCODER -- requirements
Module: composite_encoder

---
 rtl/composite_encoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/composite_encoder.sv
// rtl/composite_encoder.sv - 4-stage composite video (NTSC/PAL) sample encoder.
// Define COMPOSITE_ENCODER_CLAMP_EN to saturate dacSample instead of wrapping.
module composite_encoder #(
    parameter int DAC_BITS   = 5,
    parameter int PHASE_BITS = 4
) (
    input  logic                  phaseClock,
    input  logic                  reset,
    input  logic [PHASE_BITS-1:0] subcarrierPhase,
    input  logic                  palMode,
    input  logic                  blank,
    input  logic                  sync,
    input  logic                  burst,
    input  logic                  linePhase,
    input  logic signed [8:0]     y,
    input  logic signed [8:0]     u,
    input  logic signed [8:0]     v,
    output logic [DAC_BITS-1:0]   dacSample,
    output logic                  syncOut
);

    localparam int TABLE_SIZE = 2 ** PHASE_BITS;
    localparam int QUARTER    = 2 ** (PHASE_BITS - 2);
    localparam int S          = 16 - DAC_BITS;

    localparam logic [DAC_BITS-1:0] SYNC_LEVEL  = '0;
    localparam logic [DAC_BITS-1:0] BLANK_LEVEL = DAC_BITS'(2 ** (DAC_BITS - 2));
    localparam logic signed [17:0]  ROUND_HALF  = 18'(2 ** (S - 1));
    localparam logic signed [17:0]  BLANK_SCALED =
        18'((2 ** (DAC_BITS - 2)) * (2 ** S) + 2 ** (S - 1));

    function automatic logic signed [7:0] cos_entry(input int k);
        real ang;
        real val;
        int  r;
        ang = 2.0 * 3.14159265358979 * $itor(k) / $itor(TABLE_SIZE);
        val = 127.0 * $cos(ang);
        if (val >= 0.0) r = $rtoi(val + 0.5);
        else            r = -$rtoi(0.5 - val);
        return 8'(r);
    endfunction

    logic signed [7:0] cos_tab [TABLE_SIZE];

    for (genvar k = 0; k < TABLE_SIZE; k++) begin : g_cos
        assign cos_tab[k] = cos_entry(k);
    end

    // sine is the cosine a quarter period earlier; the subtraction wraps in PHASE_BITS
    logic [PHASE_BITS-1:0] sin_idx;
    assign sin_idx = subcarrierPhase - PHASE_BITS'(QUARTER);

    logic [DAC_BITS-1:0] sel_offset;
    logic signed [8:0]   sel_y;
    logic signed [8:0]   sel_u;
    logic signed [8:0]   sel_v;

    always_comb begin
        sel_offset = BLANK_LEVEL;
        sel_y      = '0;
        sel_u      = '0;
        sel_v      = '0;
        if (sync) begin
            sel_offset = SYNC_LEVEL;
        end else if (burst) begin
            sel_u = palMode ? -9'sd45 : -9'sd64;
            sel_v = palMode ? (linePhase ? 9'sd45 : -9'sd45) : 9'sd0;
        end else if (!blank) begin
            sel_y = y;
            sel_u = u;
            sel_v = (palMode && !linePhase) ? -v : v;
        end
    end

    logic [DAC_BITS-1:0] s1_offset;
    logic signed [8:0]   s1_y;
    logic signed [8:0]   s1_u;
    logic signed [8:0]   s1_v;
    logic signed [7:0]   s1_cos;
    logic signed [7:0]   s1_sin;
    logic                s1_sync;

    always_ff @(posedge phaseClock) begin
        if (reset) begin
            s1_offset <= BLANK_LEVEL;
            s1_y      <= '0;
            s1_u      <= '0;
            s1_v      <= '0;
            s1_cos    <= '0;
            s1_sin    <= '0;
            s1_sync   <= 1'b0;
        end else begin
            s1_offset <= sel_offset;
            s1_y      <= sel_y;
            s1_u      <= sel_u;
            s1_v      <= sel_v;
            s1_cos    <= cos_tab[subcarrierPhase];
            s1_sin    <= cos_tab[sin_idx];
            s1_sync   <= sync;
        end
    end

    logic signed [17:0] u_ext;
    logic signed [17:0] v_ext;
    logic signed [17:0] cos_ext;
    logic signed [17:0] sin_ext;
    logic        [17:0] offset_ext;

    assign u_ext      = {{9{s1_u[8]}}, s1_u};
    assign v_ext      = {{9{s1_v[8]}}, s1_v};
    assign cos_ext    = {{10{s1_cos[7]}}, s1_cos};
    assign sin_ext    = {{10{s1_sin[7]}}, s1_sin};
    assign offset_ext = {{(18 - DAC_BITS){1'b0}}, s1_offset};

    logic signed [17:0] s2_y;
    logic signed [17:0] s2_u;
    logic signed [17:0] s2_v;
    logic signed [17:0] s2_off;
    logic               s2_sync;

    always_ff @(posedge phaseClock) begin
        if (reset) begin
            s2_y    <= '0;
            s2_u    <= '0;
            s2_v    <= '0;
            s2_off  <= BLANK_SCALED;
            s2_sync <= 1'b0;
        end else begin
            s2_y    <= {{2{s1_y[8]}}, s1_y, 7'd0};
            s2_u    <= u_ext * cos_ext;
            s2_v    <= v_ext * sin_ext;
            s2_off  <= $signed((offset_ext << S) + ROUND_HALF);
            s2_sync <= s1_sync;
        end
    end

    logic signed [17:0] acc;
    logic               s3_sync;

    always_ff @(posedge phaseClock) begin
        if (reset) begin
            acc     <= BLANK_SCALED;
            s3_sync <= 1'b0;
        end else begin
            acc     <= s2_y + s2_u + s2_v + s2_off;
            s3_sync <= s2_sync;
        end
    end

    logic [DAC_BITS-1:0] out_code;

`ifdef COMPOSITE_ENCODER_CLAMP_EN
    localparam logic signed [17:0] MAX_CODE = 18'(2 ** DAC_BITS - 1);
    logic signed [17:0] acc_shift;
    assign acc_shift = acc >>> S;

    always_comb begin
        out_code = acc_shift[DAC_BITS-1:0];
        if (acc < 0)                  out_code = '0;
        else if (acc_shift > MAX_CODE) out_code = MAX_CODE[DAC_BITS-1:0];
    end
`else
    logic unused_acc_bits;
    assign unused_acc_bits = ^{acc[17:S+DAC_BITS], acc[S-1:0]};
    assign out_code        = acc[S+DAC_BITS-1:S];
`endif

    always_ff @(posedge phaseClock) begin
        if (reset) begin
            dacSample <= BLANK_LEVEL;
            syncOut   <= 1'b0;
        end else begin
            dacSample <= out_code;
            syncOut   <= s3_sync;
        end
    end

endmodule
